// File: rtl/ring_counter_pkg.sv
// Shared constants and home-state helpers for the ring / Johnson shift counter.
// Home helpers return 64-bit values already masked to the requested width.
package ring_counter_pkg;

    localparam logic MODE_RING    = 1'b0;
    localparam logic MODE_JOHNSON = 1'b1;
    localparam logic DIR_UP       = 1'b0;
    localparam logic DIR_DOWN     = 1'b1;

    localparam int unsigned MAX_WIDTH = 64;

    function automatic logic [63:0] width_mask(input int unsigned w);
        return (w >= MAX_WIDTH) ? {64{1'b1}} : ((64'd1 << w) - 64'd1);
    endfunction

    function automatic logic [63:0] ring_home(input int unsigned w);
        return 64'd1 & width_mask(w);
    endfunction

    function automatic logic [63:0] johnson_home(input int unsigned w);
        return 64'd0 & width_mask(w);
    endfunction

endpackage

// File: rtl/ring_state_check.sv
// Combinational legality and home-state detector for a counter value under a mode.
// Ring: exactly one bit set. Johnson: 0..01..1 or 1..10..0 (all-0 and all-1 included).
module ring_state_check
    import ring_counter_pkg::*;
#(
    parameter int unsigned WIDTH = 8
) (
    input  logic [WIDTH-1:0] q_i,
    input  logic             mode_i,
    output logic             legal_o,
    output logic             home_o
);

    localparam logic [63:0]      RING_HOME_W    = ring_home(WIDTH);
    localparam logic [63:0]      JOHNSON_HOME_W = johnson_home(WIDTH);
    localparam logic [WIDTH-1:0] RING_HOME      = RING_HOME_W[WIDTH-1:0];
    localparam logic [WIDTH-1:0] JOHNSON_HOME   = JOHNSON_HOME_W[WIDTH-1:0];
    localparam logic [WIDTH-1:0] ONE            = {{(WIDTH-1){1'b0}}, 1'b1};

    logic [WIDTH-1:0] q_minus1;
    logic [WIDTH-1:0] q_plus1;
    logic [WIDTH-1:0] q_inv;
    logic [WIDTH-1:0] q_inv_plus1;
    logic             ring_legal;
    logic             low_thermo;
    logic             high_thermo;

    // x & (x+1) == 0 holds exactly when x is a run of ones anchored at bit 0.
    assign q_minus1    = q_i - ONE;
    assign q_plus1     = q_i + ONE;
    assign q_inv       = ~q_i;
    assign q_inv_plus1 = q_inv + ONE;

    assign ring_legal  = (q_i != '0) && ((q_i & q_minus1) == '0);
    assign low_thermo  = ((q_i & q_plus1) == '0);
    assign high_thermo = ((q_inv & q_inv_plus1) == '0);

    always_comb begin
        legal_o = 1'b0;
        home_o  = 1'b0;
        if (mode_i == MODE_JOHNSON) begin
            legal_o = low_thermo || high_thermo;
            home_o  = (q_i == JOHNSON_HOME);
        end else begin
            legal_o = ring_legal;
            home_o  = (q_i == RING_HOME);
        end
    end

endmodule

// File: rtl/ring_johnson_counter.sv
// Parametrised one-hot ring / Johnson shift counter with direction, enable,
// parallel load, illegal-state correction (Fault pulse) and home-return Wrap pulse.
module ring_johnson_counter
    import ring_counter_pkg::*;
#(
    parameter int unsigned WIDTH = 8
) (
    input  logic             clk_i,
    input  logic             rst_i,
    input  logic             en_i,
    input  logic             dir_i,
    input  logic             mode_i,
    input  logic             load_i,
    input  logic [WIDTH-1:0] load_value_i,
    output logic [WIDTH-1:0] q_o,
    output logic             wrap_o,
    output logic             fault_o
);

    localparam logic [63:0]      RING_HOME_W    = ring_home(WIDTH);
    localparam logic [63:0]      JOHNSON_HOME_W = johnson_home(WIDTH);
    localparam logic [WIDTH-1:0] RING_HOME      = RING_HOME_W[WIDTH-1:0];
    localparam logic [WIDTH-1:0] JOHNSON_HOME   = JOHNSON_HOME_W[WIDTH-1:0];

    logic [WIDTH-1:0] q_q, q_d;
    logic             wrap_q, wrap_d;
    logic             fault_q, fault_d;

    logic [WIDTH-1:0] shift_val;
    logic [WIDTH-1:0] home_val;
    logic             fb_up;
    logic             fb_down;
    logic             cur_legal;
    logic             cur_home;
    logic             shift_legal;
    logic             shift_home;

    ring_state_check #(.WIDTH(WIDTH)) u_cur_check (
        .q_i     (q_q),
        .mode_i  (mode_i),
        .legal_o (cur_legal),
        .home_o  (cur_home)
    );

    ring_state_check #(.WIDTH(WIDTH)) u_shift_check (
        .q_i     (shift_val),
        .mode_i  (mode_i),
        .legal_o (shift_legal),
        .home_o  (shift_home)
    );

    // Johnson inverts the bit that wraps around; ring passes it straight through.
    assign fb_up    = (mode_i == MODE_JOHNSON) ? ~q_q[WIDTH-1] : q_q[WIDTH-1];
    assign fb_down  = (mode_i == MODE_JOHNSON) ? ~q_q[0]       : q_q[0];
    assign home_val = (mode_i == MODE_JOHNSON) ? JOHNSON_HOME  : RING_HOME;

    always_comb begin
        shift_val = q_q;
        if (dir_i == DIR_UP) begin
            shift_val = {q_q[WIDTH-2:0], fb_up};
        end else begin
            shift_val = {fb_down, q_q[WIDTH-1:1]};
        end
    end

    always_comb begin
        q_d     = q_q;
        wrap_d  = 1'b0;
        fault_d = 1'b0;
        if (load_i) begin
            q_d = load_value_i;
        end else if (!cur_legal) begin
            q_d     = home_val;
            fault_d = 1'b1;
        end else if (en_i) begin
            q_d = shift_val;
            // A shift out of a legal state always leaves home, so ~cur_home never masks a real wrap.
            wrap_d = shift_home && shift_legal && !cur_home;
        end
    end

    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            q_q     <= RING_HOME;
            wrap_q  <= 1'b0;
            fault_q <= 1'b0;
        end else begin
            q_q     <= q_d;
            wrap_q  <= wrap_d;
            fault_q <= fault_d;
        end
    end

    assign q_o     = q_q;
    assign wrap_o  = wrap_q;
    assign fault_o = fault_q;

endmodule

// File: tb/tb_ring_johnson_counter.sv
// Directed bench for ring_johnson_counter at WIDTH=4 with hand-computed expectations.
module tb_ring_johnson_counter;

    logic       clk;
    logic       rst;
    logic       en;
    logic       dir;
    logic       mode;
    logic       load;
    logic [3:0] load_value;
    logic [3:0] q;
    logic       wrap;
    logic       fault;

    int checks = 0;
    int errors = 0;

    ring_johnson_counter #(.WIDTH(4)) dut (
        .clk_i        (clk),
        .rst_i        (rst),
        .en_i         (en),
        .dir_i        (dir),
        .mode_i       (mode),
        .load_i       (load),
        .load_value_i (load_value),
        .q_o          (q),
        .wrap_o       (wrap),
        .fault_o      (fault)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [3:0] obs, input logic [3:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%b expected=%b", tag, obs, exp);
        end
    endtask

    // Advance one rising edge, settle, then check Q, Wrap and Fault.
    task automatic step(input string tag, input logic [3:0] exp_q,
                        input logic exp_wrap, input logic exp_fault);
        @(posedge clk);
        #1;
        chk({tag, ".q"},     q,           exp_q);
        chk({tag, ".wrap"},  {3'b0, wrap},  {3'b0, exp_wrap});
        chk({tag, ".fault"}, {3'b0, fault}, {3'b0, exp_fault});
    endtask

    logic [3:0] johnson_up [8];
    logic [3:0] johnson_dn [8];

    initial begin
        johnson_up = '{4'b0001, 4'b0011, 4'b0111, 4'b1111, 4'b1110, 4'b1100, 4'b1000, 4'b0000};
        johnson_dn = '{4'b1000, 4'b1100, 4'b1110, 4'b1111, 4'b0111, 4'b0011, 4'b0001, 4'b0000};

        rst = 1'b1; en = 1'b0; dir = 1'b0; mode = 1'b0; load = 1'b0; load_value = 4'b0000;
        @(posedge clk);
        #1;
        chk("reset.q", q, 4'b0001);
        rst = 1'b0;

        // Move away from home, then reset asynchronously between edges.
        load = 1'b1; load_value = 4'b0100;
        step("preload", 4'b0100, 1'b0, 1'b0);
        load = 1'b0;
        @(negedge clk);
        rst = 1'b1;
        #1;
        chk("async_rst.q",     q,             4'b0001);
        chk("async_rst.wrap",  {3'b0, wrap},  4'b0000);
        chk("async_rst.fault", {3'b0, fault}, 4'b0000);
        #1;
        rst = 1'b0;
        step("hold0", 4'b0001, 1'b0, 1'b0);
        step("hold1", 4'b0001, 1'b0, 1'b0);

        // Ring up through a full period.
        mode = 1'b0; dir = 1'b0; en = 1'b1;
        step("ring1", 4'b0010, 1'b0, 1'b0);
        step("ring2", 4'b0100, 1'b0, 1'b0);
        step("ring3", 4'b1000, 1'b0, 1'b0);
        step("ring4", 4'b0001, 1'b1, 1'b0);
        en = 1'b0;
        step("ring_hold", 4'b0001, 1'b0, 1'b0);

        // Johnson up then down, each a full 8-shift period.
        load = 1'b1; load_value = 4'b0000;
        step("jload", 4'b0000, 1'b0, 1'b0);
        load = 1'b0; mode = 1'b1; dir = 1'b0; en = 1'b1;
        for (int i = 0; i < 8; i++) begin
            step($sformatf("jup%0d", i), johnson_up[i], (i == 7), 1'b0);
        end
        dir = 1'b1;
        for (int i = 0; i < 8; i++) begin
            step($sformatf("jdn%0d", i), johnson_dn[i], (i == 7), 1'b0);
        end

        // Illegal loads are shown for one cycle, then corrected.
        en = 1'b0; mode = 1'b0; dir = 1'b0;
        load = 1'b1; load_value = 4'b0110;
        step("rbad_load", 4'b0110, 1'b0, 1'b0);
        load = 1'b0;
        step("rbad_fix", 4'b0001, 1'b0, 1'b1);
        step("rbad_after", 4'b0001, 1'b0, 1'b0);
        mode = 1'b1;
        load = 1'b1; load_value = 4'b0101;
        step("jbad_load", 4'b0101, 1'b0, 1'b0);
        load = 1'b0;
        step("jbad_fix", 4'b0000, 1'b0, 1'b1);

        // Mode switches: 0100 is not a thermometer value, 1000 is.
        mode = 1'b0; en = 1'b0;
        load = 1'b1; load_value = 4'b0100;
        step("sw_a_load", 4'b0100, 1'b0, 1'b0);
        load = 1'b0; mode = 1'b1; en = 1'b1;
        step("sw_a_fix", 4'b0000, 1'b0, 1'b1);
        mode = 1'b0; en = 1'b0;
        load = 1'b1; load_value = 4'b1000;
        step("sw_b_load", 4'b1000, 1'b0, 1'b0);
        load = 1'b0; mode = 1'b1; en = 1'b1;
        step("sw_b_shift", 4'b0000, 1'b1, 1'b0);
        en = 1'b0;
        load = 1'b1; load_value = 4'b0111;
        step("sw_c_load", 4'b0111, 1'b0, 1'b0);
        load = 1'b0; mode = 1'b0;
        step("sw_c_fix", 4'b0001, 1'b0, 1'b1);

        // Load beats shift; then alternate direction every edge.
        mode = 1'b0; en = 1'b1; dir = 1'b0;
        load = 1'b1; load_value = 4'b0100;
        step("ld_en", 4'b0100, 1'b0, 1'b0);
        load = 1'b0;
        for (int i = 0; i < 4; i++) begin
            dir = logic'(i % 2);
            step($sformatf("dir_tog%0d", i), (i % 2 == 0) ? 4'b1000 : 4'b0100, 1'b0, 1'b0);
        end

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

    initial begin
        #100000;
        errors++;
        $display("FAIL timeout observed=running expected=finished");
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $fatal(1, "timeout");
    end

endmodule
